// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO expansion board front ends (switch reader, display driver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } scan_state_t;

    localparam int GPIO_NBITS    = 32;
    localparam int GPIO_CLK_DIV  = 25;
    localparam int GPIO_DEBOUNCE = 3;

endpackage

// File: rtl/gpio_tick_gen.sv
// Phase timer: pulses tick once every CLK_DIV clocks, realigned by restart.
// Latency: first tick on the CLK_DIV-th clock after a restart.
// Backpressure: none; free-running.
module gpio_tick_gen
    import gpio_pkg::*;
#(
    parameter int CLK_DIV = GPIO_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= RELOAD;
        end else if (restart || cnt == 8'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == 8'd0);

endmodule

// File: rtl/gpio_switch_reader.sv
// Scans the switch bank shift register, debounces across frames, presents a stable word.
// Latency: frame = CLK_DIV + 2*NBITS*CLK_DIV + 1 clocks; sw updates one clock after DONE.
// Backpressure: none; frames run back-to-back while enable is high.
module gpio_switch_reader
    import gpio_pkg::*;
#(
    parameter int NBITS    = GPIO_NBITS,
    parameter int CLK_DIV  = GPIO_CLK_DIV,
    parameter int DEBOUNCE = GPIO_DEBOUNCE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ser_in,
    output logic             ser_clk,
    output logic             ser_load_n,
    output logic [NBITS-1:0] sw,
    output logic             sw_changed,
    output logic             frame_done
);

    localparam int             BW        = $clog2(NBITS);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(NBITS - 1);
    localparam logic [3:0]     MATCH_MAX = 4'(DEBOUNCE - 1);

    scan_state_t      state, state_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic             ser_clk_d;
    logic             sample;
    logic             tick;
    logic             restart;
    logic [NBITS-1:0] frame;
    logic [NBITS-1:0] prev_frame;
    logic [3:0]       match_cnt, match_d;
    logic             commit;

    gpio_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // ser_clk doubles as the SHIFT phase: 0 = low phase, 1 = high phase.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        ser_clk_d = 1'b0;
        sample    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_clk_d = ser_clk;
                if (tick) begin
                    if (!ser_clk) begin
                        sample    = 1'b1;
                        ser_clk_d = 1'b1;
                    end else begin
                        ser_clk_d = 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt + BW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = enable ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        restart = (state_d != state);
    end

    // match_d counts this frame; commit only once the run of equal frames is long enough.
    always_comb begin
        match_d = 4'd0;
        if (frame == prev_frame) begin
            match_d = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 4'd1;
        end
        commit = (state == ST_DONE) && (match_d == MATCH_MAX) && (frame != sw);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            ser_clk    <= 1'b0;
            ser_load_n <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            ser_clk    <= ser_clk_d;
            ser_load_n <= (state_d != ST_LOAD);
            frame_done <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame      <= '0;
            prev_frame <= '0;
            match_cnt  <= 4'd0;
            sw         <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= commit;
            if (sample) begin
                frame <= {frame[NBITS-2:0], ser_in};
            end
            if (state == ST_DONE) begin
                match_cnt <= match_d;
                if (frame != prev_frame) prev_frame <= frame;
            end
            if (commit) begin
                sw <= frame;
            end
        end
    end

endmodule

// File: tb/tb_gpio_switch_reader.sv
// Bench for gpio_switch_reader: 8-bit/CLK_DIV=2/DEBOUNCE=3 instance plus a 32-bit unfiltered instance,
// each driven by a parallel-load shift register board model.
module tb_gpio_switch_reader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // 8-bit instance
    logic        enable8 = 1'b0;
    logic        ser_in8;
    logic        ser_clk8, load_n8, sw_changed8, frame_done8;
    logic [7:0]  sw8;
    logic [7:0]  board8 = 8'h00;
    logic [7:0]  sreg8;
    logic        sclk8_q;

    // 32-bit unfiltered instance
    logic        enable32 = 1'b0;
    logic        ser_in32;
    logic        ser_clk32, load_n32, sw_changed32, frame_done32;
    logic [31:0] sw32;
    logic [31:0] board32 = 32'h0;
    logic [31:0] sreg32;
    logic        sclk32_q;

    gpio_switch_reader #(.NBITS(8), .CLK_DIV(2), .DEBOUNCE(3)) dut8 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable8),
        .ser_in     (ser_in8),
        .ser_clk    (ser_clk8),
        .ser_load_n (load_n8),
        .sw         (sw8),
        .sw_changed (sw_changed8),
        .frame_done (frame_done8)
    );

    gpio_switch_reader #(.NBITS(32), .CLK_DIV(2), .DEBOUNCE(1)) dut32 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable32),
        .ser_in     (ser_in32),
        .ser_clk    (ser_clk32),
        .ser_load_n (load_n32),
        .sw         (sw32),
        .sw_changed (sw_changed32),
        .frame_done (frame_done32)
    );

    // Board: loads while load_n is low, shifts one place after each ser_clk rise.
    always_ff @(posedge clock) begin
        sclk8_q <= ser_clk8;
        if (!load_n8) sreg8 <= board8;
        else if (ser_clk8 && !sclk8_q) sreg8 <= {sreg8[6:0], 1'b0};
    end
    assign ser_in8 = sreg8[7];

    always_ff @(posedge clock) begin
        sclk32_q <= ser_clk32;
        if (!load_n32) sreg32 <= board32;
        else if (ser_clk32 && !sclk32_q) sreg32 <= {sreg32[30:0], 1'b0};
    end
    assign ser_in32 = sreg32[31];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] board;
        logic       exp_chg;
        logic [7:0] exp_sw;
    } vec_t;

    vec_t vecs[19];
    logic carry_low = 1'b0;

    // Runs one frame of the 8-bit instance. With cont=1 the caller already sampled clock k=1.
    // Returns frame metrics plus sw/sw_changed sampled on the clock after frame_done.
    task automatic run_frame(input logic [7:0] val, input bit cont,
                             output int period, output int lowcnt, output int rises,
                             output int first_rise, output int chg_mid,
                             output logic chg_post, output logic [7:0] sw_post);
        bit   seen;
        logic pclk;
        board8     = val;
        period     = cont ? 1 : 0;
        lowcnt     = (cont && carry_low) ? 1 : 0;
        rises      = 0;
        first_rise = 0;
        chg_mid    = 0;
        seen       = 1'b0;
        pclk       = ser_clk8;
        while (!seen && period < 200) begin
            @(negedge clock);
            period++;
            if (!load_n8) lowcnt++;
            if (ser_clk8 && !pclk) begin
                rises++;
                if (first_rise == 0) first_rise = period;
            end
            pclk = ser_clk8;
            if (sw_changed8) chg_mid++;
            if (frame_done8) seen = 1'b1;
        end
        if (!seen) period = -1;
        @(negedge clock);
        chg_post  = sw_changed8;
        sw_post   = sw8;
        carry_low = !load_n8;
    endtask

    initial begin
        int         p, lc, rs, fr, cm, k, viol;
        logic       cp, pclk;
        logic [7:0] sp;

        vecs[0]  = '{8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{8'hA5, 1'b1, 8'hA5};
        vecs[3]  = '{8'hA5, 1'b0, 8'hA5};
        vecs[4]  = '{8'hA5, 1'b0, 8'hA5};
        for (int i = 5; i < 15; i++) begin
            vecs[i] = '{((i % 2) == 1) ? 8'h3C : 8'hA5, 1'b0, 8'hA5};
        end
        vecs[15] = '{8'h3C, 1'b0, 8'hA5};
        vecs[16] = '{8'h3C, 1'b0, 8'hA5};
        vecs[17] = '{8'h3C, 1'b1, 8'h3C};
        vecs[18] = '{8'h3C, 1'b0, 8'h3C};

        // Commit A5, then reset in the middle of the next frame's SHIFT.
        repeat (3) @(negedge clock);
        reset   = 1'b1;
        @(negedge clock);
        enable8 = 1'b1;
        run_frame(8'hA5, 1'b0, p, lc, rs, fr, cm, cp, sp);
        run_frame(8'hA5, 1'b1, p, lc, rs, fr, cm, cp, sp);
        run_frame(8'hA5, 1'b1, p, lc, rs, fr, cm, cp, sp);
        check("pre_reset_sw", 64'(sw8), 64'h00A5);
        repeat (15) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_load_n", 64'(load_n8), 64'd1);
        check("rst_ser_clk", 64'(ser_clk8), 64'd0);
        check("rst_sw", 64'(sw8), 64'd0);
        check("rst_sw_changed", 64'(sw_changed8), 64'd0);
        check("rst_frame_done", 64'(frame_done8), 64'd0);
        enable8 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!load_n8 || ser_clk8 || frame_done8 || sw_changed8 || sw8 != 8'h00) viol++;
        end
        check("idle_quiet", 64'(viol), 64'd0);

        // Frame shape and debounce / bounce rejection, one table row per frame.
        enable8 = 1'b1;
        for (int i = 0; i < 19; i++) begin
            run_frame(vecs[i].board, (i > 0), p, lc, rs, fr, cm, cp, sp);
            check($sformatf("f%0d_period", i), 64'(p), 64'd35);
            check($sformatf("f%0d_load_low", i), 64'(lc), 64'd2);
            check($sformatf("f%0d_rises", i), 64'(rs), 64'd8);
            check($sformatf("f%0d_first_rise", i), 64'(fr), 64'd5);
            check($sformatf("f%0d_chg_mid", i), 64'(cm), 64'd0);
            check($sformatf("f%0d_sw_changed", i), 64'(cp), 64'(vecs[i].exp_chg));
            check($sformatf("f%0d_sw", i), 64'(sp), 64'(vecs[i].exp_sw));
        end

        // Enable dropped during bit 4: frame still completes, then IDLE.
        board8 = 8'h3C;
        k      = 1;
        rs     = 0;
        pclk   = ser_clk8;
        p      = -1;
        while (p < 0 && k < 200) begin
            @(negedge clock);
            k++;
            if (ser_clk8 && !pclk) begin
                rs++;
                if (rs == 4) enable8 = 1'b0;
            end
            pclk = ser_clk8;
            if (frame_done8) p = k;
        end
        check("drop_period", 64'(p), 64'd35);
        check("drop_rises", 64'(rs), 64'd8);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!load_n8 || ser_clk8 || frame_done8 || sw_changed8) viol++;
        end
        check("drop_idle", 64'(viol), 64'd0);
        check("drop_sw", 64'(sw8), 64'h003C);
        enable8 = 1'b1;
        @(negedge clock);
        check("reenable_load", 64'(load_n8), 64'd0);
        enable8 = 1'b0;

        // Unfiltered 32-bit instance: first frame updates sw directly.
        board32  = 32'hDEADBEEF;
        enable32 = 1'b1;
        k        = 0;
        p        = -1;
        while (p < 0 && k < 400) begin
            @(negedge clock);
            k++;
            if (frame_done32) p = k;
        end
        check("w32_period", 64'(p), 64'd131);
        check("w32_sw_at_done", 64'(sw32), 64'd0);
        @(negedge clock);
        check("w32_sw", 64'(sw32), 64'hDEADBEEF);
        check("w32_sw_changed", 64'(sw_changed32), 64'd1);
        enable32 = 1'b0;
        @(negedge clock);
        check("w32_pulse_width", 64'(sw_changed32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
